// File: rtl/mem_access_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : mem_access_unit_if                                       |
// | Description : Execute-side, data-memory and writeback signal bundle    |
// |               for the load/store unit.                                 |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
interface mem_access_unit_if;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rd;

    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_data;

    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misaligned;
    logic        bus_error;

    // master: the load/store unit itself (it masters the data-memory bus)
    modport master (
        input  ex_valid, ex_is_load, ex_is_store, ex_funct3, ex_addr, ex_wdata, ex_rd,
        input  dmem_req_ready, dmem_resp_valid, dmem_resp_data,
        output ex_ready, dmem_req_valid, dmem_addr, dmem_wdata, dmem_wmask,
        output wb_valid, wb_rd, wb_data, misaligned, bus_error
    );

    // slave: the surrounding pipeline and data memory
    modport slave (
        output ex_valid, ex_is_load, ex_is_store, ex_funct3, ex_addr, ex_wdata, ex_rd,
        output dmem_req_ready, dmem_resp_valid, dmem_resp_data,
        input  ex_ready, dmem_req_valid, dmem_addr, dmem_wdata, dmem_wmask,
        input  wb_valid, wb_rd, wb_data, misaligned, bus_error
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : mem_access_unit                                          |
// | Description : Single-outstanding load/store stage with lane steering,  |
// |               load extension, misalignment and response timeout.       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mem_access_unit_if.master bus
);
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic        is_load_q, is_load_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        misaligned_q, misaligned_d;
    logic        bus_error_q, bus_error_d;

    logic        w_misaligned;
    logic [31:0] w_lane_wdata;
    logic [3:0]  w_lane_mask;
    logic [31:0] w_shifted;
    logic [31:0] w_load_data;

    always_comb begin
        unique case (bus.ex_funct3)
            3'b000, 3'b100: w_misaligned = 1'b0;
            3'b001, 3'b101: w_misaligned = bus.ex_addr[0];
            3'b010:         w_misaligned = (bus.ex_addr[1:0] != 2'b00);
            default:        w_misaligned = 1'b1;
        endcase
    end

    always_comb begin
        w_lane_wdata = bus.ex_wdata;
        w_lane_mask  = 4'b1111;
        unique case (bus.ex_funct3[1:0])
            2'b00: begin
                w_lane_wdata = {4{bus.ex_wdata[7:0]}};
                w_lane_mask  = 4'b0001 << bus.ex_addr[1:0];
            end
            2'b01: begin
                w_lane_wdata = {2{bus.ex_wdata[15:0]}};
                w_lane_mask  = 4'b0011 << bus.ex_addr[1:0];
            end
            default: begin
                w_lane_wdata = bus.ex_wdata;
                w_lane_mask  = 4'b1111;
            end
        endcase
    end

    // Bring the addressed byte/half down to bit 0, then extend by load type.
    assign w_shifted = bus.dmem_resp_data >> {off_q, 3'b000};

    always_comb begin
        unique case (funct3_q)
            3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
            3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        is_load_d    = is_load_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        rd_d         = rd_q;
        cnt_d        = cnt_q;
        wb_valid_d   = 1'b0;
        wb_data_d    = wb_data_q;
        misaligned_d = 1'b0;
        bus_error_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.ex_valid) begin
                    addr_d    = {bus.ex_addr[31:2], 2'b00};
                    off_d     = bus.ex_addr[1:0];
                    wdata_d   = w_lane_wdata;
                    wmask_d   = bus.ex_is_load ? 4'b0000 : w_lane_mask;
                    is_load_d = bus.ex_is_load;
                    funct3_d  = bus.ex_funct3;
                    rd_d      = bus.ex_rd;
                    if (bus.ex_is_load || bus.ex_is_store) begin
                        if (w_misaligned) begin
                            misaligned_d = 1'b1;
                        end else begin
                            state_d = S_REQ;
                        end
                    end
                end
            end
            S_REQ: begin
                if (bus.dmem_req_ready) begin
                    cnt_d   = 8'd0;
                    state_d = is_load_q ? S_WAIT : S_IDLE;
                end
            end
            S_WAIT: begin
                // A response arriving on the final allowed cycle still wins.
                if (bus.dmem_resp_valid) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = w_load_data;
                    state_d    = S_IDLE;
                end else if (cnt_q == c_TIMEOUT_LAST) begin
                    bus_error_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            wmask_q      <= 4'd0;
            is_load_q    <= 1'b0;
            funct3_q     <= 3'd0;
            off_q        <= 2'd0;
            rd_q         <= 5'd0;
            cnt_q        <= 8'd0;
            wb_valid_q   <= 1'b0;
            wb_data_q    <= 32'd0;
            misaligned_q <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            is_load_q    <= is_load_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            rd_q         <= rd_d;
            cnt_q        <= cnt_d;
            wb_valid_q   <= wb_valid_d;
            wb_data_q    <= wb_data_d;
            misaligned_q <= misaligned_d;
            bus_error_q  <= bus_error_d;
        end
    end

    assign bus.ex_ready       = (state_q == S_IDLE);
    assign bus.dmem_req_valid = (state_q == S_REQ);
    assign bus.dmem_addr      = addr_q;
    assign bus.dmem_wdata     = wdata_q;
    assign bus.dmem_wmask     = wmask_q;
    assign bus.wb_valid       = wb_valid_q;
    assign bus.wb_rd          = rd_q;
    assign bus.wb_data        = wb_data_q;
    assign bus.misaligned     = misaligned_q;
    assign bus.bus_error      = bus_error_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_mem_access_unit                                       |
// | Description : Randomised self-checking bench with transaction model.   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_mem_access_unit;
    localparam int c_TO = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    mem_access_unit_if bus ();

    mem_access_unit #(.TIMEOUT_CYCLES(c_TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] mask; logic chk_wdata; } req_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; int at; } wb_t;

    req_t req_q[$];
    wb_t  wb_q[$];
    int   mis_q[$];
    int   err_q[$];

    req_t        exp_req;
    wb_t         exp_wb;
    int          exp_at;
    logic [31:0] last_wb_data = 32'd0;
    int          last_wb_at = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference rules written as plain arithmetic on byte counts.
    function automatic logic model_misaligned(input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return (a % 2) != 0;
            3'd2:       return (a % 4) != 0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [35:0] model_store(input logic [2:0] f3, input logic [1:0] o, input logic [31:0] d);
        int          nbytes;
        logic [31:0] rep;
        logic [3:0]  m;
        nbytes = 1 << f3[1:0];
        if (nbytes == 1)      rep = (d & 32'hFF) * 32'h01010101;
        else if (nbytes == 2) rep = (d & 32'hFFFF) * 32'h00010001;
        else                  rep = d;
        m = 4'((((1 << nbytes) - 1) << o) & 15);
        return {m, rep};
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] o, input logic [31:0] r);
        logic [31:0] v;
        v = r >> (8 * o);
        case (f3)
            3'd0:    return ((v & 32'hFF) ^ 32'h80) - 32'h80;
            3'd4:    return v & 32'hFF;
            3'd1:    return ((v & 32'hFFFF) ^ 32'h8000) - 32'h8000;
            3'd5:    return v & 32'hFFFF;
            default: return v;
        endcase
    endfunction

    // Compare process: every observable event must match the head of its queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.dmem_req_valid) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", 32'd1, 32'd0);
                end else begin
                    exp_req = req_q[0];
                    chk("req_addr", bus.dmem_addr, exp_req.addr);
                    chk("req_wmask", {28'd0, bus.dmem_wmask}, {28'd0, exp_req.mask});
                    if (exp_req.chk_wdata) chk("req_wdata", bus.dmem_wdata, exp_req.wdata);
                    chk("ready_low_busy", {31'd0, bus.ex_ready}, 32'd0);
                    if (bus.dmem_req_ready) void'(req_q.pop_front());
                end
            end
            if (bus.wb_valid) begin
                if (wb_q.size() == 0) begin
                    chk("unexpected_wb", 32'd1, 32'd0);
                end else begin
                    exp_wb = wb_q.pop_front();
                    chk("wb_rd", {27'd0, bus.wb_rd}, {27'd0, exp_wb.rd});
                    chk("wb_data", bus.wb_data, exp_wb.data);
                    chk("wb_cycle", cyc, exp_wb.at);
                    last_wb_data = bus.wb_data;
                    last_wb_at   = cyc;
                end
            end
            if (bus.misaligned) begin
                if (mis_q.size() == 0) chk("unexpected_misaligned", 32'd1, 32'd0);
                else begin exp_at = mis_q.pop_front(); chk("misaligned_cycle", cyc, exp_at); end
            end
            if (bus.bus_error) begin
                if (err_q.size() == 0) chk("unexpected_bus_error", 32'd1, 32'd0);
                else begin exp_at = err_q.pop_front(); chk("bus_error_cycle", cyc, exp_at); end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, input int rdy_dly,
                         input int resp_dly, input logic [31:0] rdata, output int t0);
        int          guard;
        int          tw;
        logic        bad;
        logic [35:0] lanes;
        guard = 0;
        while (!bus.ex_ready && guard < 20) begin tick(); guard++; end
        if (!bus.ex_ready) chk("ex_ready_timeout", 32'd0, 32'd1);
        bus.ex_valid = 1'b1; bus.ex_is_load = ld; bus.ex_is_store = st;
        bus.ex_funct3 = f3; bus.ex_addr = addr; bus.ex_wdata = wdata; bus.ex_rd = rd;
        t0    = cyc;
        bad   = model_misaligned(f3, addr);
        lanes = model_store(f3, addr[1:0], wdata);
        if ((ld || st) && bad) mis_q.push_back(t0 + 1);
        else if (ld) req_q.push_back('{addr & 32'hFFFF_FFFC, 32'd0, 4'd0, 1'b0});
        else if (st) req_q.push_back('{addr & 32'hFFFF_FFFC, lanes[31:0], lanes[35:32], 1'b1});
        tick();
        bus.ex_valid = 1'b0;
        if (!(ld || st)) return;
        if (bad) begin
            chk("ready_after_misaligned", {31'd0, bus.ex_ready}, 32'd1);
            return;
        end
        for (int i = 0; i <= rdy_dly; i++) begin
            bus.dmem_req_ready  = (i == rdy_dly);
            bus.ex_valid        = 1'($urandom_range(0, 1));
            bus.ex_is_load      = 1'($urandom_range(0, 1));
            bus.ex_is_store     = 1'($urandom_range(0, 1));
            bus.dmem_resp_valid = 1'($urandom_range(0, 1));
            bus.dmem_resp_data  = $urandom;
            tick();
        end
        bus.dmem_req_ready = 1'b0; bus.ex_valid = 1'b0; bus.dmem_resp_valid = 1'b0;
        if (!ld) return;
        tw = cyc;
        if (resp_dly < c_TO) begin
            repeat (resp_dly) tick();
            bus.dmem_resp_valid = 1'b1;
            bus.dmem_resp_data  = rdata;
            wb_q.push_back('{rd, model_load(f3, addr[1:0], rdata), cyc + 1});
            tick();
            bus.dmem_resp_valid = 1'b0;
            bus.dmem_resp_data  = $urandom;
        end else begin
            err_q.push_back(tw + c_TO);
            repeat (c_TO) tick();
            bus.dmem_resp_valid = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t0;
        int          k;
        logic        ld, st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [35:0] pin;
        logic [2:0]  ldf3 [5];
        logic [2:0]  badf3 [3];
        ldf3  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        badf3 = '{3'd3, 3'd6, 3'd7};

        bus.ex_valid = 1'b0; bus.ex_is_load = 1'b0; bus.ex_is_store = 1'b0; bus.ex_funct3 = 3'd0;
        bus.ex_addr = 32'd0; bus.ex_wdata = 32'd0; bus.ex_rd = 5'd0;
        bus.dmem_req_ready = 1'b0; bus.dmem_resp_valid = 1'b0; bus.dmem_resp_data = 32'd0;

        pin = model_store(3'd0, 2'd3, 32'h0000_00A5);
        chk("pin_sb_wdata", pin[31:0], 32'hA5A5_A5A5);
        chk("pin_sb_mask", {28'd0, pin[35:32]}, 32'h8);
        chk("pin_lb", model_load(3'd0, 2'd2, 32'h12F0_3456), 32'hFFFF_FFF0);
        chk("pin_lbu", model_load(3'd4, 2'd2, 32'h12F0_3456), 32'h0000_00F0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ex_ready", {31'd0, bus.ex_ready}, 32'd1);
        chk("rst_outputs", {27'd0, bus.dmem_req_valid, bus.wb_valid, bus.misaligned, bus.bus_error, 1'b0}, 32'd0);
        chk("rst_addr_mask", bus.dmem_addr | {28'd0, bus.dmem_wmask}, 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        tick();

        do_op(1'b0, 1'b1, 3'd2, 32'h104, 32'hDEAD_BEEF, 5'd0, 0, 0, 32'd0, t0);
        do_op(1'b0, 1'b1, 3'd0, 32'h103, 32'h0000_00A5, 5'd0, 0, 0, 32'd0, t0);
        do_op(1'b1, 1'b0, 3'd0, 32'h202, 32'd0, 5'd7, 0, 0, 32'h12F0_3456, t0);
        @(negedge clk); #1;
        chk("lb_literal", last_wb_data, 32'hFFFF_FFF0);
        chk("lb_latency", last_wb_at, t0 + 3);
        do_op(1'b1, 1'b0, 3'd4, 32'h202, 32'd0, 5'd8, 0, 0, 32'h12F0_3456, t0);
        @(negedge clk); #1;
        chk("lbu_literal", last_wb_data, 32'h0000_00F0);
        do_op(1'b1, 1'b0, 3'd1, 32'h201, 32'd0, 5'd9, 0, 0, 32'd0, t0);
        do_op(1'b1, 1'b0, 3'd2, 32'h400, 32'd0, 5'd0, 5, 0, 32'hCAFE_F00D, t0);
        do_op(1'b1, 1'b0, 3'd2, 32'h404, 32'd0, 5'd3, 0, c_TO, 32'd0, t0);
        do_op(1'b1, 1'b0, 3'd5, 32'h40A, 32'd0, 5'd4, 1, c_TO - 1, 32'h8001_7FFF, t0);

        // Reset while a load is waiting drops it silently.
        bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_is_store = 1'b0;
        bus.ex_funct3 = 3'd2; bus.ex_addr = 32'h300; bus.ex_rd = 5'd5;
        req_q.push_back('{32'h300, 32'd0, 4'd0, 1'b0});
        tick();
        bus.ex_valid = 1'b0; bus.dmem_req_ready = 1'b1;
        tick();
        bus.dmem_req_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        #1;
        chk("rst_wait_ready", {31'd0, bus.ex_ready}, 32'd1);
        tick();
        reset = 1'b0;
        repeat (c_TO + 3) tick();
        chk("post_rst_ready", {31'd0, bus.ex_ready}, 32'd1);

        for (int n = 0; n < 300; n++) begin
            k  = $urandom_range(0, 19);
            ld = (k < 9) || (k == 16) || (k == 17);
            st = (k >= 9 && k < 18);
            if (ld) f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : ldf3[$urandom_range(0, 4)];
            else    f3 = ($urandom_range(0, 9) == 0) ? badf3[$urandom_range(0, 2)] : 3'($urandom_range(0, 2));
            a = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                if (f3[1:0] == 2'd1) a[0] = 1'b0;
                if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
            end
            repeat ($urandom_range(0, 2)) tick();
            do_op(ld, st, f3, a, $urandom, 5'($urandom), $urandom_range(0, 3),
                  $urandom_range(0, c_TO + 1), $urandom, t0);
        end

        repeat (c_TO + 4) tick();
        chk("req_queue_empty", req_q.size(), 32'd0);
        chk("wb_queue_empty", wb_q.size(), 32'd0);
        chk("mis_queue_empty", mis_q.size(), 32'd0);
        chk("err_queue_empty", err_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
